// File: rtl/dac_sched_pkg.sv
// Shared state encoding and default widths
// for the SPI DAC frame scheduler.
package dac_sched_pkg;

  localparam int DATA_W   = 24;
  localparam int DIV_W    = 16;
  localparam int CH_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    NEXT
  } sched_state_e;

endpackage

// File: rtl/dac_frame_timer.sv
// Free-running frame period counter that
// emits one tick per programmed period.
module dac_frame_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] frame_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] div_clamped;

  assign div_clamped = (frame_div < DIV_W'(2))
                     ? DIV_W'(2) : frame_div;

  assign tick = enable &&
                (cnt_q == period_q - DIV_W'(1));

  // Count while enabled; reload the period at every wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      period_q <= DIV_W'(2);
    end else if (!enable || tick) begin
      cnt_q    <= '0;
      period_q <= div_clamped;
    end else begin
      cnt_q    <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_dac_scheduler.sv
// Frame scheduler sharing one SPI transmitter
// across NUM_CH channel FIFOs.
module spi_dac_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = dac_sched_pkg::DATA_W,
  parameter int DIV_W   = dac_sched_pkg::DIV_W,
  parameter int BUSY_TO = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           frame_div,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          ch_empty,
  output logic [NUM_CH-1:0]          ch_read,
  output logic [DATA_W-1:0]          spi_data,
  output logic                       spi_fifo_empty,
  input  logic                       spi_fifo_read,
  output logic                       spi_start,
  input  logic                       spi_busy,
  output logic [dac_sched_pkg::CH_IDX_W-1:0] active_ch,
  output logic                       frame_done,
  output logic                       underrun,
  output logic [7:0]                 underrun_count,
  output logic                       overrun,
  output logic                       spi_error
);

  import dac_sched_pkg::*;

  localparam int BC_W = $clog2(BUSY_TO + 1);

  typedef logic [CH_IDX_W-1:0] idx_t;

  sched_state_e      state_q;
  sched_state_e      state_d;
  idx_t              ch_q;
  idx_t              ch_d;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] mask_d;
  logic [BC_W-1:0]   busy_cnt_q;
  logic [7:0]        urun_cnt_q;
  logic              overrun_q;
  logic              error_q;

  logic              tick;
  logic              first_hit;
  idx_t              first_idx;
  logic              next_hit;
  idx_t              next_idx;
  logic              sel_empty;
  logic [DATA_W-1:0] sel_data;
  logic              in_xfer;
  logic              set_error;
  logic              busy_timeout;

  dac_frame_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .frame_div(frame_div),
    .tick     (tick)
  );

  assign in_xfer = (state_q == START) ||
                   (state_q == WAIT_BUSY) ||
                   (state_q == WAIT_DONE);

  assign busy_timeout =
    (busy_cnt_q >= BC_W'(BUSY_TO - 1));

  // Lowest live-mask channel and next channel above the current one.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        first_hit = 1'b1;
        first_idx = idx_t'(k);
      end
      if (mask_q[k] && (idx_t'(k) > ch_q)) begin
        next_hit = 1'b1;
        next_idx = idx_t'(k);
      end
    end
  end

  // Route the selected FIFO onto the transmitter.
  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    ch_read   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == idx_t'(k)) begin
        sel_empty  = ch_empty[k];
        sel_data   = ch_data[k*DATA_W +: DATA_W];
        ch_read[k] = in_xfer & spi_fifo_read;
      end
    end
  end

  assign spi_data       = in_xfer ? sel_data : '0;
  assign spi_fifo_empty = in_xfer ? sel_empty : 1'b1;
  assign spi_start      = (state_q == START);
  assign active_ch      = ch_q;
  assign underrun_count = urun_cnt_q;
  assign overrun        = overrun_q;
  assign spi_error      = error_q;

  // Next-state logic and per-cycle event pulses.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mask_d     = mask_q;
    frame_done = 1'b0;
    underrun   = 1'b0;
    set_error  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (first_hit) begin
            mask_d  = ch_mask;
            ch_d    = first_idx;
            state_d = SELECT;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      SELECT: begin
        if (sel_empty) begin
          underrun = 1'b1;
          state_d  = NEXT;
        end else begin
          state_d  = START;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = WAIT_DONE;
        end else if (busy_timeout) begin
          set_error = 1'b1;
          state_d   = NEXT;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) state_d = NEXT;
      end
      NEXT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (next_hit) begin
          ch_d    = next_idx;
          state_d = SELECT;
        end else begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, current channel and frame mask.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mask_q  <= mask_d;
    end
  end

  // Busy watchdog, underrun counter and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_cnt_q <= '0;
      urun_cnt_q <= '0;
      overrun_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (state_q == START) begin
        busy_cnt_q <= BC_W'(1);
      end else if (state_q == WAIT_BUSY) begin
        busy_cnt_q <= busy_cnt_q + BC_W'(1);
      end
      if (underrun && (urun_cnt_q != 8'hFF)) begin
        urun_cnt_q <= urun_cnt_q + 8'd1;
      end
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (set_error) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule
